// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receive stage: 2-flop input synchronizer, tick divider,
// start/data/parity/stop FSM and registered byte/strobe outputs.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
    parameter int ClkFreq        = 16000000,
    parameter int BaudRate       = 1000000,
    parameter int OversampleRate = 16,
    parameter int DataBits       = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter int ParityOdd      = 0
`endif
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_rxd_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int SampleClk = BaudRate * OversampleRate;
    localparam int DivRound  = (ClkFreq + SampleClk / 2) / SampleClk;
    localparam int Div       = (DivRound < 1) ? 1 : DivRound;
    localparam int DivW      = (Div > 1) ? $clog2(Div) : 1;
    localparam int OsW       = $clog2(OversampleRate);

    localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
    localparam logic [OsW-1:0]  OsLast  = OsW'(OversampleRate - 1);
    localparam logic [OsW-1:0]  OsHalf  = OsW'(OversampleRate / 2 - 1);
    localparam logic [3:0]      BitLast = 4'(DataBits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [DivW-1:0]       div_cnt;
    logic [OsW-1:0]        os_cnt;
    logic                  tick;
    logic                  mid_sample;
    logic [3:0]            bit_idx;
    logic [DataBits-1:0]   shreg;
    logic                  armed;
`ifdef UART_RX_PARITY_EN
    logic                  par_acc;
    logic                  par_mismatch;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rxd_i;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: transitions only happen at mid-bit samples after IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_sample) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_sample && (bit_idx == BitLast)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_sample) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (mid_sample) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational FSM outputs: oversample tick, mid-bit sample enable, busy
    always_comb begin
        tick       = (state != IDLE) && (div_cnt == DivLast);
        mid_sample = 1'b0;
        busy_o     = (state != IDLE);
        if (tick) begin
            if (state == START) begin
                mid_sample = (os_cnt == OsHalf);
            end else begin
                mid_sample = (os_cnt == OsLast);
            end
        end
    end

    // Datapath: counters, arming, shift register and registered strobes
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            div_cnt      <= '0;
            os_cnt       <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            armed        <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc      <= 1'b0;
            par_mismatch <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif

            if ((state == IDLE) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if ((state == IDLE) || mid_sample) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= os_cnt + 1'b1;
            end

            if ((state == IDLE) && rx_s) begin
                armed <= 1'b1;
            end

            if (mid_sample) begin
                case (state)
                    START: begin
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_acc      <= 1'b0;
                        par_mismatch <= 1'b0;
`endif
                    end
                    DATA: begin
                        shreg   <= {rx_s, shreg[DataBits-1:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_acc <= par_acc ^ rx_s;
`endif
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        par_mismatch <= rx_s ^ par_acc ^ (ParityOdd != 0);
                    end
`endif
                    STOP: begin
                        data_o <= 8'(shreg);
                        if (rx_s) begin
                            data_valid_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_o <= par_mismatch;
`endif
                        end else begin
                            frame_err_o <= 1'b1;
                            armed       <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Oversampling UART receive stage. Turns the asynchronous serial line into parallel bytes.
- Feeds the CPU-side UART register block, which pushes each byte into its RX FIFO.
- Output is a byte plus a one-clock valid strobe, so it connects directly to a FIFO write-enable and write-data.
- Also reports framing errors and, optionally, parity errors.

Parameters:
- ClkFreq, 16000000, system clock frequency in Hz.
- BaudRate, 1000000, serial bit rate in bits/s.
- OversampleRate, 16, ticks per bit; must be even and at least 8.
- DataBits, 8, payload bits per frame; legal range 5..8. data_o is always 8 bits wide.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-low reset.
- uart_rxd_i  input  1  asynchronous serial line; idles high.
- data_o  output  8  received byte, LSB-aligned; unused upper bits are 0.
- data_valid_o  output  1  one-clock pulse; data_o is valid in the same cycle.
- frame_err_o  output  1  one-clock pulse: stop bit sampled low.
- parity_err_o  output  1  one-clock pulse: parity mismatch (macro only; tied 0 otherwise).
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_i low at a clk_i edge):
  - Synchronizer flops load 1.
  - FSM goes to IDLE; tick divider and bit counters clear; armed clears.
  - data_o=0, data_valid_o=0, frame_err_o=0, parity_err_o=0, busy_o=0.
  - A reset mid-frame abandons the frame with no strobe.
- Input sync: uart_rxd_i passes through a 2-flop synchronizer. All logic uses rx_s, the second flop output.
- Tick generator:
  - Divider DIV = round(ClkFreq/(BaudRate*OversampleRate)), minimum 1.
  - Counter runs 0..DIV-1 and emits a one-clock tick at DIV-1.
  - Counter is held at 0 while in IDLE and restarts on IDLE exit.
  - With DIV=1, tick is high every clock.
- Arming: the armed flag sets when rx_s=1 is seen in IDLE. A start edge is only accepted while armed. A line stuck low after reset or after a break never starts a frame.
- FSM states:
  - IDLE: armed and rx_s=0 -> START; tick count clears.
  - START: on tick OversampleRate/2-1, sample rx_s.
    - rx_s=1 (glitch): -> IDLE, no strobe.
    - rx_s=0: -> DATA; bit index clears.
  - DATA: every OversampleRate ticks (mid-bit), shift rx_s in LSB-first and increment the bit index. After DataBits samples -> PARITY if the macro is on, else STOP.
  - PARITY: sample at mid-bit, compare with the configured parity, latch the mismatch -> STOP.
  - STOP: sample at mid-bit.
    - rx_s=1: data_valid_o=1 for one clock; parity_err_o pulses in that same cycle if a mismatch was latched.
    - rx_s=0: frame_err_o=1 for one clock, data_valid_o stays 0, armed clears.
    - Either way -> IDLE at the mid-stop sample, leaving half a bit of resync margin.
- Output timing:
  - Strobes are registered and assert the clock after the mid-stop sample.
  - data_o updates in the same cycle as the strobe and holds until the next strobe. It also updates on frame error, so firmware can inspect the bad byte.
- Frame timing: the data_valid_o rising edge is 2 + (1+DataBits+P+0.5)*OversampleRate*DIV clocks (±1) after the uart_rxd_i falling edge, where P=1 with parity, else 0.
- Back-to-back frames: a new start bit arriving right after the stop midpoint is accepted with no lost frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Extra parameter ParityOdd, default 0 (0 = even parity).
  - FSM includes the PARITY state.
  - parity_err_o is live and is qualified by the stop bit. It only pulses together with data_valid_o; on a framing error, parity_err_o stays 0.
- Undefined: no PARITY state, no ParityOdd parameter, parity_err_o tied 0.

Test Plan (ClkFreq=16e6, BaudRate=1e6, OversampleRate=16, so DIV=1 and 16 clocks per bit):
- Reset release, then frame 0xA5 8N1 -> single data_valid_o pulse 154±1 clocks after the falling edge; data_o=0xA5; frame_err_o=0.
- 8-clock low glitch on an idle line -> START aborts at the mid-start sample; no strobes; busy_o drops back to 0.
- Frame 0x3C with the stop bit driven low -> frame_err_o pulses, data_valid_o=0, data_o=0x3C. Line then held low for 200 clocks -> no new frame until the line goes high; then 0x11 is received correctly.
- Frames 0x00, 0xFF, 0x55 sent back-to-back with exactly one stop bit each -> three valid pulses, spaced 160 clocks apart, data in order.
- reset_i pulsed low for 1 clock midway through the data bits of 0x81 -> no strobes for that frame; the next frame 0x42 is received correctly.
- With UART_RX_PARITY_EN and ParityOdd=0: 0x07 with parity bit 1 -> valid, no parity_err_o. 0x07 with parity bit 0 -> data_valid_o and parity_err_o pulse in the same cycle.
